uart_apb_cmd_responder: RTL and testbench

- Consumes the received UART byte stream from the rx FIFO read port and decodes fixed-format command frames.
- Executes one APB master transfer per frame.
- Pushes response bytes into the tx FIFO write port.
- Forms the bridge's command end: the host issues frames, and this block answers them.

---
 rtl/uart_apb_cmd_responder.sv | 150 +++++++++++++++
 tb/tb_uart_apb_cmd_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_cmd_responder.sv
// Command end of the UART-to-APB bridge: decodes W/R frames from the rx FIFO,
// runs one APB transfer per frame and pushes the status/read-data reply into the tx FIFO.
module uart_apb_cmd_responder #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000,
  parameter logic [7:0]  CMD_WR      = 8'h57,
  parameter logic [7:0]  CMD_RD      = 8'h52,
  parameter logic [7:0]  RSP_OK      = 8'h4B,
  parameter logic [7:0]  RSP_ERR     = 8'h45
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_rd_data,
  input  logic        rx_rd_valid,
  output logic        rx_rd_req,
  output logic [7:0]  tx_wr_data,
  output logic        tx_wr_req,
  input  logic        tx_wr_ready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, SETUP, ACCESS, RESP} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] tmo_cnt;
  logic [7:0]  status;
  logic [31:0] rdata;
  logic [2:0]  resp_idx;
  logic [2:0]  last_idx;

  // Pop is combinational so a first-word-fall-through byte is taken in the cycle it shows up.
  assign rx_rd_req = rx_rd_valid && (state == IDLE || state == ADDR || state == WDATA);
  assign last_idx  = pwrite ? 3'd0 : 3'd4;

  function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [7:0] st,
                                           input logic [31:0] d);
    case (idx)
      3'd0:    resp_byte = st;
      3'd1:    resp_byte = d[31:24];
      3'd2:    resp_byte = d[23:16];
      3'd3:    resp_byte = d[15:8];
      default: resp_byte = d[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      tmo_cnt    <= 24'd0;
      status     <= 8'h00;
      rdata      <= 32'h0;
      resp_idx   <= 3'd0;
      tx_wr_data <= 8'h00;
      tx_wr_req  <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= 32'h0;
      pwdata     <= 32'h0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rd_req) begin
            tmo_cnt  <= 24'd0;
            byte_cnt <= 2'd0;
            if (rx_rd_data == CMD_WR) begin
              pwrite <= 1'b1;
              state  <= ADDR;
            end else if (rx_rd_data == CMD_RD) begin
              pwrite <= 1'b0;
              state  <= ADDR;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        ADDR, WDATA: begin
          if (rx_rd_req) begin
            tmo_cnt  <= 24'd0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == ADDR) paddr  <= {paddr[23:0], rx_rd_data};
            else               pwdata <= {pwdata[23:0], rx_rd_data};
            if (byte_cnt == 2'd3) begin
              if (state == ADDR && pwrite) begin
                state <= WDATA;
              end else begin
                state <= SETUP;
                psel  <= 1'b1;
              end
            end
          end else if (tmo_cnt == TIMEOUT_CYC - 24'd1) begin
            // Partial frame abandoned; paddr/pwdata intentionally keep their stale contents.
            state     <= IDLE;
            frame_err <= 1'b1;
            byte_cnt  <= 2'd0;
            tmo_cnt   <= 24'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            status   <= pslverr ? RSP_ERR : RSP_OK;
            if (!pwrite) rdata <= prdata;
            resp_idx <= 3'd0;
            state    <= RESP;
          end
        end

        RESP: begin
          if (!tx_wr_req) begin
            tx_wr_req  <= 1'b1;
            tx_wr_data <= resp_byte(resp_idx, status, rdata);
          end else if (tx_wr_ready) begin
            if (resp_idx == last_idx) begin
              tx_wr_req <= 1'b0;
              state     <= IDLE;
            end else begin
              resp_idx   <= resp_idx + 3'd1;
              tx_wr_data <= resp_byte(resp_idx + 3'd1, status, rdata);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_cmd_responder.sv
// Directed bench for uart_apb_cmd_responder: FIFO-style rx source, APB slave driven
// from tasks, tx sink log; each scenario task checks its own hand-computed results.
module tb_uart_apb_cmd_responder;

  localparam logic [23:0] TMO = 24'd100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_rd_data;
  logic        rx_rd_valid;
  logic        rx_rd_req;
  logic [7:0]  tx_wr_data;
  logic        tx_wr_req;
  logic        tx_wr_ready;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  uart_apb_cmd_responder #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_rd_data(rx_rd_data), .rx_rd_valid(rx_rd_valid), .rx_rd_req(rx_rd_req),
    .tx_wr_data(tx_wr_data), .tx_wr_req(tx_wr_req), .tx_wr_ready(tx_wr_ready),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_mem [0:63];
  int rx_wr_ptr = 0;
  int rx_rd_ptr = 0;
  assign rx_rd_valid = (rx_wr_ptr != rx_rd_ptr);
  assign rx_rd_data  = rx_mem[rx_rd_ptr % 64];

  logic [7:0]  tx_log [0:63];
  int          tx_cnt = 0;
  int          cyc = 0, last_pop_cyc = 0, psel_rise_cyc = 0, fe_cnt = 0, fe_cyc = 0;
  int          xfer_cnt = 0, setup_cnt = 0, en_cnt = 0;
  logic        psel_d = 1'b0;
  logic [31:0] x_addr = 32'h0, x_wdata = 32'h0;
  logic        x_write = 1'b0;

  // Passive monitor: rx pops, APB phases, frame_err pulses and accepted tx bytes.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    psel_d <= psel;
    if (rx_rd_req && rx_rd_valid) begin
      rx_rd_ptr    <= rx_rd_ptr + 1;
      last_pop_cyc <= cyc;
    end
    if (psel && !psel_d) psel_rise_cyc <= cyc;
    if (psel && !penable) setup_cnt <= setup_cnt + 1;
    if (psel && penable) en_cnt <= en_cnt + 1;
    if (psel && penable && pready) begin
      xfer_cnt <= xfer_cnt + 1;
      x_addr   <= paddr;
      x_wdata  <= pwdata;
      x_write  <= pwrite;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (tx_wr_req && tx_wr_ready) begin
      tx_log[tx_cnt % 64] <= tx_wr_data;
      tx_cnt <= tx_cnt + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wr_ptr % 64] = b;
    rx_wr_ptr = rx_wr_ptr + 1;
  endtask

  task automatic push4(input logic [31:0] w);
    push(w[31:24]); push(w[23:16]); push(w[15:8]); push(w[7:0]);
  endtask

  // Waits for the access phase, holds pready low for 'delay' cycles, then completes it.
  task automatic apb_serve(input int delay, input logic [31:0] rd, input logic err);
    int n = 0;
    pready = 1'b0; prdata = rd; pslverr = err;
    while (!(psel && penable) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!(psel && penable)) begin
      errors++;
      $display("[TB] FAIL apb_access_wait: penable=%0b required 1", penable);
    end else begin
      repeat (delay) @(negedge clk);
      pready = 1'b1;
      @(negedge clk);
      pready = 1'b0; pslverr = 1'b0;
    end
  endtask

  task automatic wait_tx(input int target, input string tag);
    int n = 0;
    while (tx_cnt < target && n < 400) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    checks++;
    if (tx_cnt != target) begin
      errors++;
      $display("[TB] FAIL %s tx_count: got %0d required %0d", tag, tx_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_wr_ready = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({psel, penable, pwrite, tx_wr_req, frame_err, rx_rd_req} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b required 000000",
               {psel, penable, pwrite, tx_wr_req, frame_err, rx_rd_req});
    end
    checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || tx_wr_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h required 0", paddr, pwdata, tx_wr_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int tx0 = tx_cnt, x0 = xfer_cnt, s0 = setup_cnt, e0 = en_cnt;
    push(8'h57); push4(32'h00001004); push4(32'hDEADBEEF);
    apb_serve(0, 32'h0, 1'b0);
    wait_tx(tx0 + 1, "write");
    checks++;
    if (xfer_cnt - x0 != 1) begin errors++; $display("[TB] FAIL write_xfers: got %0d required 1", xfer_cnt - x0); end
    checks++;
    if (x_addr !== 32'h00001004) begin errors++; $display("[TB] FAIL write_paddr: got %h required 00001004", x_addr); end
    checks++;
    if (x_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_pwdata: got %h required deadbeef", x_wdata); end
    checks++;
    if (x_write !== 1'b1) begin errors++; $display("[TB] FAIL write_pwrite: got %b required 1", x_write); end
    checks++;
    if (setup_cnt - s0 != 1 || en_cnt - e0 != 1) begin
      errors++;
      $display("[TB] FAIL write_phases: setup %0d access %0d required 1 1", setup_cnt - s0, en_cnt - e0);
    end
    checks++;
    if (psel_rise_cyc - last_pop_cyc != 1) begin
      errors++;
      $display("[TB] FAIL write_psel_latency: got %0d required 1", psel_rise_cyc - last_pop_cyc);
    end
    checks++;
    if (tx_log[tx0 % 64] !== 8'h4B) begin errors++; $display("[TB] FAIL write_status: got %h required 4b", tx_log[tx0 % 64]); end
  endtask

  task automatic test_read(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                           input logic err, input int delay);
    int tx0 = tx_cnt, x0 = xfer_cnt, e0 = en_cnt;
    logic [7:0] exp_b [5];
    exp_b = '{(err ? 8'h45 : 8'h4B), rd[31:24], rd[23:16], rd[15:8], rd[7:0]};
    push(8'h52); push4(addr);
    apb_serve(delay, rd, err);
    checks++;
    if (tx_wr_req !== 1'b0 || psel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s resp_cycle1: req %b psel %b required 0 0", tag, tx_wr_req, psel);
    end
    @(negedge clk);
    checks++;
    if (tx_wr_req !== 1'b1 || tx_wr_data !== exp_b[0]) begin
      errors++;
      $display("[TB] FAIL %s resp_cycle2: req %b data %h required 1 %h", tag, tx_wr_req, tx_wr_data, exp_b[0]);
    end
    wait_tx(tx0 + 5, tag);
    checks++;
    if (xfer_cnt - x0 != 1 || x_addr !== addr || x_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s apb: xfers %0d addr %h write %b required 1 %h 0", tag, xfer_cnt - x0, x_addr, x_write, addr);
    end
    checks++;
    if (en_cnt - e0 != delay + 1) begin
      errors++;
      $display("[TB] FAIL %s penable_cycles: got %0d required %0d", tag, en_cnt - e0, delay + 1);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_log[(tx0 + i) % 64] !== exp_b[i]) begin
        errors++;
        $display("[TB] FAIL %s tx_byte%0d: got %h required %h", tag, i, tx_log[(tx0 + i) % 64], exp_b[i]);
      end
    end
  endtask

  task automatic test_bad_bytes();
    int tx0 = tx_cnt, x0 = xfer_cnt, s0 = setup_cnt, f0 = fe_cnt;
    push(8'h00); push(8'hFF);
    push(8'h57); push4(32'h00000008); push4(32'h01020304);
    apb_serve(0, 32'h0, 1'b0);
    wait_tx(tx0 + 1, "bad_bytes");
    checks++;
    if (fe_cnt - f0 != 2) begin errors++; $display("[TB] FAIL bad_frame_err: got %0d required 2", fe_cnt - f0); end
    checks++;
    if (xfer_cnt - x0 != 1 || setup_cnt - s0 != 1) begin
      errors++;
      $display("[TB] FAIL bad_apb_count: xfers %0d setups %0d required 1 1", xfer_cnt - x0, setup_cnt - s0);
    end
    checks++;
    if (x_addr !== 32'h00000008 || x_wdata !== 32'h01020304) begin
      errors++;
      $display("[TB] FAIL bad_write: addr %h data %h required 00000008 01020304", x_addr, x_wdata);
    end
    checks++;
    if (tx_log[tx0 % 64] !== 8'h4B) begin errors++; $display("[TB] FAIL bad_status: got %h required 4b", tx_log[tx0 % 64]); end
  endtask

  task automatic test_timeout();
    int f0 = fe_cnt, x0 = xfer_cnt, n = 0;
    push(8'h57); push(8'h00); push(8'h00);
    while (fe_cnt == f0 && n < 300) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (fe_cnt - f0 != 1) begin errors++; $display("[TB] FAIL timeout_frame_err: got %0d required 1", fe_cnt - f0); end
    // frame_err rises on the TMO-th edge after the last pop and is seen by the monitor one edge later.
    checks++;
    if (fe_cyc - last_pop_cyc != int'(TMO) + 1) begin
      errors++;
      $display("[TB] FAIL timeout_cycle: got %0d required %0d", fe_cyc - last_pop_cyc, int'(TMO) + 1);
    end
    checks++;
    if (xfer_cnt != x0 || psel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_apb: xfers %0d psel %b required 0 0", xfer_cnt - x0, psel);
    end
    test_read("after_timeout", 32'h00003008, 32'hA5A55A5A, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    int tx0 = tx_cnt;
    logic [7:0] exp_b [5];
    exp_b = '{8'h4B, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    tx_wr_ready = 1'b0;
    push(8'h52); push4(32'h0000600C);
    apb_serve(0, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tx_wr_ready = ((i / 2) % 2) == 1;
      @(negedge clk);
    end
    tx_wr_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (tx_cnt - tx0 != 5) begin errors++; $display("[TB] FAIL bp_count: got %0d required 5", tx_cnt - tx0); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_log[(tx0 + i) % 64] !== exp_b[i]) begin
        errors++;
        $display("[TB] FAIL bp_byte%0d: got %h required %h", i, tx_log[(tx0 + i) % 64], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int tx0 = tx_cnt, x0 = xfer_cnt, n = 0;
    pready = 1'b0;
    push(8'h52); push4(32'h00004000);
    while (!(psel && penable) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!(psel && penable)) begin errors++; $display("[TB] FAIL rstmid_access: penable=%0b required 1", penable); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_apb_drop: psel %b penable %b required 0 0", psel, penable);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (tx_cnt != tx0 || xfer_cnt != x0 || tx_wr_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_no_resp: tx %0d xfers %0d req %b required 0 0 0", tx_cnt - tx0, xfer_cnt - x0, tx_wr_req);
    end
    push(8'h57); push4(32'h00005000); push4(32'h11223344);
    apb_serve(0, 32'h0, 1'b0);
    wait_tx(tx0 + 1, "rstmid_next");
    checks++;
    if (x_addr !== 32'h00005000 || x_wdata !== 32'h11223344 || tx_log[tx0 % 64] !== 8'h4B) begin
      errors++;
      $display("[TB] FAIL rstmid_next_frame: addr %h data %h status %h required 00005000 11223344 4b",
               x_addr, x_wdata, tx_log[tx0 % 64]);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read("read", 32'h00002000, 32'h12345678, 1'b0, 3);
    test_read("read_err", 32'h00002004, 32'h89ABCDEF, 1'b1, 0);
    test_bad_bytes();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
